// File: rtl/buck_ctrl_pkg.sv
// Shared types and defaults for the buck gate-drive controller.
package buck_ctrl_pkg;
  localparam int DEF_PERIOD    = 200;
  localparam int DEF_DEAD_TIME = 4;

  typedef enum logic [2:0] {IDLE, HS_ON, DT_HL, LS_ON, DT_LH} buck_ctrl_state_t;

  function automatic logic [31:0] clamp_duty(input logic [31:0] d, input logic [31:0] dmax);
    return (d > dmax) ? dmax : d;
  endfunction
endpackage

// File: rtl/pwm_period_cnt.sv
// Switching-period counter: wraps 0..PERIOD-1 while enabled, parks at 0 otherwise.
module pwm_period_cnt import buck_ctrl_pkg::*; #(
  parameter int PERIOD    = DEF_PERIOD,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  output logic [CNT_WIDTH-1:0] cnt,
  output logic                 period_start,
  output logic                 eop
);
  logic run;

  // eop: the coming edge opens a new period (wrap, or first edge after en rises)
  assign eop = en && (!run || (cnt == CNT_WIDTH'(PERIOD-1)));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      run          <= 1'b0;
      cnt          <= '0;
      period_start <= 1'b0;
    end else if (!en) begin
      run          <= 1'b0;
      cnt          <= '0;
      period_start <= 1'b0;
    end else begin
      run          <= 1'b1;
      period_start <= eop;
      cnt          <= eop ? '0 : cnt + 1'b1;
    end
  end
endmodule

// File: rtl/buck_pwm_ctrl.sv
// Buck gate-drive FSM: fixed-period PWM with dead time, diode emulation and
// cycle-by-cycle current limit. hs/ls decode straight from the state register.
module buck_pwm_ctrl import buck_ctrl_pkg::*; #(
  parameter int PERIOD    = DEF_PERIOD,
  parameter int DEAD_TIME = DEF_DEAD_TIME,
  parameter int CNT_WIDTH = 16,
  parameter int I_WIDTH   = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  input  logic [CNT_WIDTH-1:0]      duty,
  input  logic signed [I_WIDTH-1:0] i_ind,
  input  logic signed [I_WIDTH-1:0] ls_thresh,
  input  logic signed [I_WIDTH-1:0] i_limit,
  output logic                      hs,
  output logic                      ls,
  output logic                      ls_en,
  output logic                      period_start,
  output logic                      ilim_trip
);
  localparam logic [CNT_WIDTH-1:0] DMAX    = CNT_WIDTH'(PERIOD - 2*DEAD_TIME);
  localparam logic [CNT_WIDTH-1:0] LH_AT   = CNT_WIDTH'(PERIOD - DEAD_TIME - 1);
  localparam logic [CNT_WIDTH-1:0] DT_LAST = CNT_WIDTH'(DEAD_TIME - 1);

  buck_ctrl_state_t     state;
  logic [CNT_WIDTH-1:0] cnt, dt_cnt, duty_eff, duty_clamp;
  logic                 eop, oc, de;

  pwm_period_cnt #(.PERIOD(PERIOD), .CNT_WIDTH(CNT_WIDTH)) u_cnt (
    .clk(clk), .rst(rst), .en(en),
    .cnt(cnt), .period_start(period_start), .eop(eop)
  );

  assign duty_clamp = CNT_WIDTH'(clamp_duty(32'(duty), 32'(DMAX)));
  assign oc = (i_ind >= i_limit);
  assign de = (i_ind <= ls_thresh);
  assign hs = (state == HS_ON);
  assign ls = (state == LS_ON);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      dt_cnt    <= '0;
      duty_eff  <= '0;
      ls_en     <= 1'b0;
      ilim_trip <= 1'b0;
    end else if (!en) begin
      state     <= IDLE;
      dt_cnt    <= '0;
      ls_en     <= 1'b0;
      ilim_trip <= 1'b0;
    end else if (eop) begin
      // duty is latched here so it is already in force on the cnt==0 cycle
      duty_eff  <= duty_clamp;
      ls_en     <= 1'b1;
      ilim_trip <= 1'b0;
      dt_cnt    <= '0;
      state     <= (duty_clamp == '0) ? DT_HL : HS_ON;
    end else begin
      if ((state == DT_HL || state == LS_ON) && de) ls_en <= 1'b0;
      if (state == HS_ON && oc) ilim_trip <= 1'b1;
      if (state != IDLE && cnt == LH_AT) begin
        state <= DT_LH;
      end else begin
        case (state)
          HS_ON: if (oc || cnt == duty_eff - 1'b1) begin
            state  <= DT_HL;
            dt_cnt <= '0;
          end
          DT_HL: begin
            if (dt_cnt != DT_LAST) dt_cnt <= dt_cnt + 1'b1;
            else if (ls_en && !de) state <= LS_ON;
          end
          LS_ON: if (de) begin
            state  <= DT_HL;
            dt_cnt <= '0;
          end
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_buck_pwm_ctrl.sv
// Directed bench for buck_pwm_ctrl: one whole period is captured per scenario
// and compared against hand-derived on/off windows.
module tb_buck_pwm_ctrl;
  logic               clk, rst, en;
  logic [15:0]        duty;
  logic signed [15:0] i_ind, ls_thresh, i_limit;
  logic               hs, ls, ls_en, period_start, ilim_trip;

  int errors = 0;
  int checks = 0;
  logic [199:0] hs_v, ls_v, ps_v, le_v, tr_v;

  buck_pwm_ctrl #(.PERIOD(200), .DEAD_TIME(4), .CNT_WIDTH(16), .I_WIDTH(16)) dut (
    .clk(clk), .rst(rst), .en(en), .duty(duty), .i_ind(i_ind),
    .ls_thresh(ls_thresh), .i_limit(i_limit), .hs(hs), .ls(ls),
    .ls_en(ls_en), .period_start(period_start), .ilim_trip(ilim_trip)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [199:0] win(input int lo, input int hi);
    logic [199:0] r = '0;
    for (int i = lo; i <= hi; i++) r[i] = 1'b1;
    return r;
  endfunction

  // current ramp for diode emulation: crosses 10 at cnt=150, back to 200 at 170
  function automatic int dio(input int k);
    int v;
    if (k < 100 || k >= 170) return 200;
    v = 10 + (150 - k) * 4;
    return (v < 0) ? 0 : v;
  endfunction

  task automatic wait_ps();
    int n = 0;
    @(negedge clk);
    while (period_start !== 1'b1 && n < 400) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (period_start !== 1'b1) begin
      errors++;
      $display("FAIL wait_ps: period_start=%b after %0d cycles, required 1", period_start, n);
    end
  endtask

  // Entered on the cnt==0 negedge; leaves on the next period's cnt==0 negedge.
  task automatic capture(input int scen);
    for (int k = 0; k < 200; k++) begin
      hs_v[k] = hs; ls_v[k] = ls; ps_v[k] = period_start;
      le_v[k] = ls_en; tr_v[k] = ilim_trip;
      case (scen)
        1: i_ind = 16'(dio(k));
        2: i_ind = 16'((k <= 40) ? 600 + 10*k : 500);
        3: if (k == 50) duty = 16'd30;
        default: ;
      endcase
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if ({hs, ls, ls_en, period_start, ilim_trip} !== 5'b0 || dut.cnt !== 16'd0) begin
      errors++;
      $display("FAIL reset_out: outs=%b cnt=%0d, required 00000 cnt=0",
               {hs, ls, ls_en, period_start, ilim_trip}, dut.cnt);
    end
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({hs, ls, ls_en, period_start, ilim_trip} !== 5'b0 || dut.cnt !== 16'd0) begin
      errors++;
      $display("FAIL idle_out: outs=%b cnt=%0d, required 00000 cnt=0",
               {hs, ls, ls_en, period_start, ilim_trip}, dut.cnt);
    end
  endtask

  task automatic test_nominal();
    en = 1'b1;
    wait_ps();
    for (int p = 0; p < 2; p++) begin
      capture(0);
      checks++; if (hs_v !== win(0, 99)) begin errors++; $display("FAIL nom_hs p%0d: got %h want %h", p, hs_v, win(0, 99)); end
      checks++; if (ls_v !== win(104, 195)) begin errors++; $display("FAIL nom_ls p%0d: got %h want %h", p, ls_v, win(104, 195)); end
      checks++; if (ps_v !== win(0, 0)) begin errors++; $display("FAIL nom_ps p%0d: got %h want %h", p, ps_v, win(0, 0)); end
      checks++; if (le_v !== win(0, 199)) begin errors++; $display("FAIL nom_lsen p%0d: got %h want %h", p, le_v, win(0, 199)); end
      checks++; if (tr_v !== '0) begin errors++; $display("FAIL nom_trip p%0d: got %h want 0", p, tr_v); end
      checks++; if ((hs_v & ls_v) !== '0) begin errors++; $display("FAIL nom_overlap p%0d: got %h want 0", p, hs_v & ls_v); end
    end
  endtask

  task automatic test_duty_clamp();
    duty = 16'd300;
    wait_ps();
    capture(0);
    checks++; if (hs_v !== win(0, 191)) begin errors++; $display("FAIL clamp_hs: got %h want %h", hs_v, win(0, 191)); end
    checks++; if (ls_v !== '0) begin errors++; $display("FAIL clamp_ls: got %h want 0", ls_v); end
  endtask

  task automatic test_duty_zero();
    duty = 16'd0;
    wait_ps();
    capture(0);
    checks++; if (hs_v !== '0) begin errors++; $display("FAIL zero_hs: got %h want 0", hs_v); end
    checks++; if (ls_v !== win(4, 195)) begin errors++; $display("FAIL zero_ls: got %h want %h", ls_v, win(4, 195)); end
  endtask

  task automatic test_duty_change();
    duty = 16'd100;
    wait_ps();
    capture(3);
    checks++; if (hs_v !== win(0, 99)) begin errors++; $display("FAIL chg_hs_old: got %h want %h", hs_v, win(0, 99)); end
    capture(0);
    checks++; if (hs_v !== win(0, 29)) begin errors++; $display("FAIL chg_hs_new: got %h want %h", hs_v, win(0, 29)); end
    checks++; if (ls_v !== win(34, 195)) begin errors++; $display("FAIL chg_ls_new: got %h want %h", ls_v, win(34, 195)); end
    duty = 16'd100;
  endtask

  task automatic test_diode_emu();
    ls_thresh = 16'sd10;
    wait_ps();
    capture(1);
    checks++; if (hs_v !== win(0, 99)) begin errors++; $display("FAIL de_hs: got %h want %h", hs_v, win(0, 99)); end
    checks++; if (ls_v !== win(104, 150)) begin errors++; $display("FAIL de_ls: got %h want %h", ls_v, win(104, 150)); end
    checks++; if (le_v !== win(0, 150)) begin errors++; $display("FAIL de_lsen: got %h want %h", le_v, win(0, 150)); end
    checks++; if (ls_en !== 1'b1) begin errors++; $display("FAIL de_lsen_next: got %b want 1", ls_en); end
    ls_thresh = -16'sd1000;
    i_ind = 16'sd500;
  endtask

  task automatic test_overcurrent();
    i_limit = 16'sd1000;
    wait_ps();
    capture(2);
    checks++; if (hs_v !== win(0, 40)) begin errors++; $display("FAIL oc_hs: got %h want %h", hs_v, win(0, 40)); end
    checks++; if (ls_v !== win(45, 195)) begin errors++; $display("FAIL oc_ls: got %h want %h", ls_v, win(45, 195)); end
    checks++; if (tr_v !== win(41, 199)) begin errors++; $display("FAIL oc_trip: got %h want %h", tr_v, win(41, 199)); end
    checks++; if ({ilim_trip, hs} !== 2'b01) begin errors++; $display("FAIL oc_next: trip,hs=%b want 01", {ilim_trip, hs}); end
    i_limit = 16'sd32767;
  endtask

  task automatic test_enable();
    wait_ps();
    repeat (20) @(negedge clk);
    en = 1'b0;
    @(negedge clk);
    checks++;
    if ({hs, ls, period_start} !== 3'b0 || dut.cnt !== 16'd0) begin
      errors++;
      $display("FAIL en_drop: hs,ls,ps=%b cnt=%0d, required 000 cnt=0", {hs, ls, period_start}, dut.cnt);
    end
    repeat (3) @(negedge clk);
    checks++;
    if ({hs, ls, period_start} !== 3'b0 || dut.cnt !== 16'd0) begin
      errors++;
      $display("FAIL en_hold: hs,ls,ps=%b cnt=%0d, required 000 cnt=0", {hs, ls, period_start}, dut.cnt);
    end
    en = 1'b1;
    @(negedge clk);
    checks++;
    if ({hs, period_start} !== 2'b11 || dut.cnt !== 16'd0) begin
      errors++;
      $display("FAIL en_restore: hs,ps=%b cnt=%0d, required 11 cnt=0", {hs, period_start}, dut.cnt);
    end
    @(negedge clk);
    checks++;
    if ({hs, period_start} !== 2'b10 || dut.cnt !== 16'd1) begin
      errors++;
      $display("FAIL en_second: hs,ps=%b cnt=%0d, required 10 cnt=1", {hs, period_start}, dut.cnt);
    end
  endtask

  task automatic test_async_reset();
    wait_ps();
    repeat (120) @(negedge clk);
    checks++; if (ls !== 1'b1) begin errors++; $display("FAIL arst_pre: ls=%b want 1", ls); end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({hs, ls, ls_en, period_start, ilim_trip} !== 5'b0) begin
      errors++;
      $display("FAIL arst_out: outs=%b, required 00000", {hs, ls, ls_en, period_start, ilim_trip});
    end
    #1 rst = 1'b0;
    wait_ps();
    capture(0);
    checks++; if (hs_v !== win(0, 99)) begin errors++; $display("FAIL arst_hs: got %h want %h", hs_v, win(0, 99)); end
    checks++; if (ls_v !== win(104, 195)) begin errors++; $display("FAIL arst_ls: got %h want %h", ls_v, win(104, 195)); end
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; duty = 16'd100; i_ind = 16'sd500;
    ls_thresh = -16'sd1000; i_limit = 16'sd32767;
    test_reset();
    test_nominal();
    test_duty_clamp();
    test_duty_zero();
    test_duty_change();
    test_diode_emu();
    test_overcurrent();
    test_enable();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
